// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects the three active-low push-buttons.
// Emits one arbitrated hit pulse per accepted press, gated by the game-running flag.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] key_n,
  input  logic       game,
  output logic [2:0] hit,
  output logic [2:0] held,
  output logic       multi_press
);

  localparam int unsigned NB = 3;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the first sampled change is accepted immediately.
  localparam bit ONE_SHOT = (DEBOUNCE_CYCLES <= 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  logic [NB-1:0]    sync1_q;
  logic [NB-1:0]    sync2_q;
  logic [NB-1:0]    pressed_s;
  logic [NB-1:0]    accept;
  logic [NB-1:0]    first_accept;
  logic [NB-1:0]    held_d;
  btn_state_t       state_q [NB];
  btn_state_t       state_d [NB];
  logic [CNT_W-1:0] cnt_q   [NB];
  logic [CNT_W-1:0] cnt_d   [NB];

  // Two-flop synchroniser; flops hold the raw active-low level, so reset means released.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-button debounce: a level change needs DEBOUNCE_CYCLES consecutive agreeing samples.
  always_comb begin
    accept = '0;
    held_d = '0;
    for (int i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        RELEASED: begin
          if (pressed_s[i]) begin
            if (ONE_SHOT) begin
              state_d[i] = PRESSED;
              cnt_d[i]   = '0;
              accept[i]  = 1'b1;
            end else begin
              state_d[i] = PRESS_WAIT;
              cnt_d[i]   = CNT_ONE;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_s[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            accept[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!pressed_s[i]) begin
            if (ONE_SHOT) begin
              state_d[i] = RELEASED;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = RELEASE_WAIT;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (pressed_s[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
    end
  end

  // Lowest-index accepted press wins; the rest are dropped.
  assign first_accept = accept & (3'(~accept) + 3'd1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit         <= '0;
      held        <= '0;
      multi_press <= 1'b0;
    end else begin
      hit         <= game ? first_accept : '0;
      held        <= held_d;
      multi_press <= game & (|(accept & (accept - 3'd1)));
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random key traffic,
// compared every cycle against a run-length debounce model.
module tb_button_conditioner;

  localparam int unsigned D = 4;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] key_n  = 3'b111;
  logic       game   = 1'b1;
  logic [2:0] hit;
  logic [2:0] held;
  logic       multi_press;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [2:0] m_sync1, m_sync2, m_level, m_hit, m_held;
  logic       m_multi;
  int         m_run [3];

  always #5 clock = ~clock;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .key_n       (key_n),
    .game        (game),
    .hit         (hit),
    .held        (held),
    .multi_press (multi_press)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 3'b111;
    m_sync2 = 3'b111;
    m_level = '0;
    m_hit   = '0;
    m_held  = '0;
    m_multi = 1'b0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  // Level flips once the synchronised input has disagreed with it for D samples in a row.
  task automatic model_edge();
    logic [2:0] s;
    logic [2:0] acc;
    if (!resetn) begin
      model_reset();
    end else begin
      s   = ~m_sync2;
      acc = '0;
      for (int i = 0; i < 3; i++) begin
        if (s[i] !== m_level[i]) begin
          m_run[i]++;
          if (m_run[i] >= int'(D)) begin
            m_level[i] = s[i];
            m_run[i]   = 0;
            acc[i]     = s[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (!game)       m_hit = 3'b000;
      else if (acc[0]) m_hit = 3'b001;
      else if (acc[1]) m_hit = 3'b010;
      else if (acc[2]) m_hit = 3'b100;
      else             m_hit = 3'b000;
      m_multi = game && ($countones(acc) > 1);
      m_held  = m_level;
      m_sync2 = m_sync1;
      m_sync1 = key_n;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("model_hit", hit, m_hit);
    chk("model_held", held, m_held);
    chk("model_multi", {2'b00, multi_press}, {2'b00, m_multi});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    #3;
    chk("reset_hit", hit, 3'b000);
    chk("reset_held", held, 3'b000);
    chk("reset_multi", {2'b00, multi_press}, 3'b000);
    #5 resetn = 1'b1;
    idle(8);

    // 1: clean press on button 0
    key_n = 3'b110;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("t1_hit", hit, (k == D + 2) ? 3'b001 : 3'b000);
      if (k == D + 1) chk("t1_held_before", held, 3'b000);
      if (k == D + 2) chk("t1_held_on", held, 3'b001);
    end
    key_n = 3'b111;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == D + 1) chk("t1_held_release_pre", held, 3'b001);
      if (k == D + 2) chk("t1_held_release", held, 3'b000);
    end

    // 2: bouncing press on button 1
    key_n = 3'b101;
    for (int k = 1; k <= 3; k++) begin step(); chk("t2_glitch_hit", hit, 3'b000); end
    key_n = 3'b111;
    step();
    chk("t2_glitch_hit", hit, 3'b000);
    key_n = 3'b101;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t2_hit", hit, (k == D + 2) ? 3'b010 : 3'b000);
    end
    key_n = 3'b111;
    idle(10);

    // 3: button 2 press, bouncy release, clean release, re-press
    key_n = 3'b011;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t3_hit1", hit, (k == D + 2) ? 3'b100 : 3'b000);
    end
    for (int r = 0; r < 4; r++) begin
      key_n = 3'b111;
      for (int k = 0; k < 2; k++) begin step(); chk("t3_bounce_held", held, 3'b100); end
      key_n = 3'b011;
      step();
      chk("t3_bounce_held", held, 3'b100);
      chk("t3_bounce_hit", hit, 3'b000);
    end
    key_n = 3'b111;
    idle(10);
    chk("t3_released", held, 3'b000);
    key_n = 3'b011;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t3_hit2", hit, (k == D + 2) ? 3'b100 : 3'b000);
    end
    key_n = 3'b111;
    idle(10);

    // 4: simultaneous presses on buttons 0 and 2
    key_n = 3'b010;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t4_hit", hit, (k == D + 2) ? 3'b001 : 3'b000);
      chk("t4_multi", {2'b00, multi_press}, (k == D + 2) ? 3'b001 : 3'b000);
      if (k == D + 2) chk("t4_held", held, 3'b101);
    end
    key_n = 3'b111;
    idle(10);

    // 5: gated press, game raised while held
    game  = 1'b0;
    key_n = 3'b110;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t5_hit", hit, 3'b000);
      chk("t5_multi", {2'b00, multi_press}, 3'b000);
    end
    chk("t5_held", held, 3'b001);
    game = 1'b1;
    for (int k = 1; k <= 10; k++) begin step(); chk("t5_late_hit", hit, 3'b000); end
    key_n = 3'b111;
    idle(10);

    // 6: async reset mid PRESS_WAIT, then while PRESSED, button kept low
    key_n = 3'b110;
    idle(3);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst1_hit", hit, 3'b000);
    chk("t6_rst1_held", held, 3'b000);
    model_reset();
    idle(2);
    @(negedge clock) resetn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t6_hit1", hit, (k == D + 2) ? 3'b001 : 3'b000);
    end
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst2_held", held, 3'b000);
    chk("t6_rst2_multi", {2'b00, multi_press}, 3'b000);
    model_reset();
    idle(2);
    @(negedge clock) resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t6_hit2", hit, (k == D + 2) ? 3'b001 : 3'b000);
    end
    key_n = 3'b111;
    idle(10);

    // Random key traffic with occasional game gating
    for (int b = 0; b < 120; b++) begin
      key_n = 3'($urandom);
      game  = ($urandom_range(0, 7) != 0);
      idle(int'($urandom_range(1, 9)));
    end
    key_n = 3'b111;
    game  = 1'b1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
